// File: rtl/if_id_buffer.sv
// Elastic IF/ID stage: small FIFO of {PC+4, instruction} with synchronous flush.
// Optional stall/flush performance counters are enabled by defining IFID_PERF_EN.
module if_id_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_pc4,
    input  logic [DATA_W-1:0]            in_instr,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_pc4,
    output logic [DATA_W-1:0]            out_instr,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef IFID_PERF_EN
    ,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  flush_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0]  wrptr_q, wrptr_d;
    logic [PTR_W-1:0]  rdptr_q, rdptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] hold_pc4_q;

    logic push, pop;

    // Ready depends on registered count only, keeping ID off the IF timing path.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign occupancy = count_q;

    assign out_instr = out_valid ? instr_mem_q[rdptr_q] : '0;
    assign out_pc4   = out_valid ? pc_mem_q[rdptr_q] : hold_pc4_q;

    always_comb begin
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        count_d = count_q;
        if (flush) begin
            wrptr_d = '0;
            rdptr_d = '0;
            count_d = '0;
        end else begin
            if (push) wrptr_d = wrptr_q + PTR_W'(1);
            if (pop)  rdptr_d = rdptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrptr_q    <= '0;
            rdptr_q    <= '0;
            count_q    <= '0;
            hold_pc4_q <= '0;
        end else begin
            wrptr_q    <= wrptr_d;
            rdptr_q    <= rdptr_d;
            count_q    <= count_d;
            hold_pc4_q <= out_pc4;
        end
    end

    // Payload storage needs no reset: it is only visible while count is non-zero.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem_q[wrptr_q]    <= in_pc4;
            instr_mem_q[wrptr_q] <= in_instr;
        end
    end

`ifdef IFID_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;
    logic [32:0] flush_sum;

    assign flush_sum = {1'b0, flush_cnt_q} + 33'(count_q) + 33'(in_valid);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush)
                flush_cnt_q <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end
`endif

endmodule
